// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, memory, execute and writeback steps,
// with a bounded wait on mem_ready and an absorbing FAULT state.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic [3:0] mem_w,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_w_en,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       fault
);

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 2);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StLui      = 4'd12,
        StAuipc    = 4'd13,
        StFault    = 4'd15
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              timeout;
    logic              taken;
    logic              load_f3_ok;
    logic              store_f3_ok;

    // Fires on the cycle whose missing mem_ready would make the wait reach MEM_TIMEOUT.
    assign timeout     = !mem_ready && ((32'(cnt_q) + 32'd1) >= MEM_TIMEOUT);
    assign load_f3_ok  = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign store_f3_ok = (funct3 inside {3'b000, 3'b001, 3'b010});

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_w      = 4'b0000;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_w_en   = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_src    = 3'b000;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    state_d    = StDecode;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
                case (op_code)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StFault;
                endcase
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op_code == OpStore) begin
                    imm_src = 3'b001;
                    state_d = store_f3_ok ? StMemWrite : StFault;
                end else if (op_code == OpLoad) begin
                    state_d = load_f3_ok ? StMemRead : StFault;
                end else begin
                    state_d = StFault;
                end
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = {funct3, 1'b0};
                if (mem_ready)    state_d = StMemWb;
                else if (timeout) state_d = StFault;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_w_en   = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = {funct3, 1'b1};
                if (mem_ready)    state_d = StFetch;
                else if (timeout) state_d = StFault;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = StAluWb;
            end
            StAluWb: begin
                reg_w_en = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                if (funct3[2:1] == 2'b01) begin
                    state_d = StFault;
                end else begin
                    pc_write = taken;
                    state_d  = StFetch;
                end
            end
            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StJalr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StLui: begin
                imm_src    = 3'b100;
                result_src = 2'b11;
                state_d    = StAluWb;
            end
            StAuipc: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                state_d   = StAluWb;
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase

        // Strobes must not leak while reset holds the FSM in FETCH.
        if (!rst_n) begin
            mem_req  = 1'b0;
            mem_w[0] = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
            reg_w_en = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (!mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign fault = (state_q == StFault);

endmodule
